// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, serializer state encoding and
// small helpers used by uart_tx (and available to uart_rx).
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int calc_divisor(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Parity bit for a data byte; odd=1 selects odd parity, odd=0 even parity.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO between the byte producer and the serializer.
// Pushes are ignored when full and pops when empty; DEPTH must be a power of two.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer, LSB first, idle high.
// Define UART_TX_PARITY_EN to insert a parity bit (sense from PARITY_ODD) before stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int BIT_W   = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVISOR - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_parity_cfg_check
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  uart_state_e          state_r, state_s;
  logic [CNT_W-1:0]     baud_cnt_r, baud_cnt_s;
  logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 tx_r, tx_s;
  logic                 bit_end_s;
  logic                 fifo_pop_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [7:0]           fifo_data_s;
`ifdef UART_TX_PARITY_EN
  logic                 parity_r, parity_s;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (tx_valid),
    .wr_data (tx_data),
    .pop     (fifo_pop_s),
    .rd_data (fifo_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign bit_end_s = (baud_cnt_r == CNT_LAST);
  assign tx_ready  = !fifo_full_s;
  assign tx_busy   = (state_r != ST_IDLE) || !fifo_empty_s;
  assign tx        = tx_r;

  // Serializer state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= '0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      tx_r       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      baud_cnt_r <= baud_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      tx_r       <= tx_s;
`ifdef UART_TX_PARITY_EN
      parity_r   <= parity_s;
`endif
    end
  end

  // Next state, next line level (tx is registered, so it leads by one edge) and FIFO pop
  always_comb begin
    state_s    = state_r;
    baud_cnt_s = bit_end_s ? '0 : baud_cnt_r + CNT_W'(1);
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    tx_s       = tx_r;
    fifo_pop_s = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_s   = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        baud_cnt_s = '0;
        bit_cnt_s  = '0;
        tx_s       = 1'b1;
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          shift_s    = fifo_data_s;
          state_s    = ST_START;
          tx_s       = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_s   = calc_parity(fifo_data_s, 1'(PARITY_ODD));
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_s   = ST_DATA;
          bit_cnt_s = '0;
          tx_s      = shift_r[0];
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
          if (bit_cnt_r == DATA_LAST) begin
            bit_cnt_s = '0;
`ifdef UART_TX_PARITY_EN
            state_s   = ST_PARITY;
            tx_s      = parity_r;
`else
            state_s   = ST_STOP;
            tx_s      = 1'b1;
`endif
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_W'(1);
            tx_s      = shift_r[1];
          end
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) begin
          state_s = ST_STOP;
          tx_s    = 1'b1;
        end else begin
          state_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (!bit_end_s) begin
          state_s = ST_STOP;
        end else if (bit_cnt_r != STOP_LAST) begin
          bit_cnt_s = bit_cnt_r + BIT_W'(1);
        end else if (!fifo_empty_s) begin
          // Back-to-back frame: next start bit follows the stop bit directly.
          fifo_pop_s = 1'b1;
          shift_s    = fifo_data_s;
          bit_cnt_s  = '0;
          state_s    = ST_START;
          tx_s       = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_s   = calc_parity(fifo_data_s, 1'(PARITY_ODD));
`endif
        end else begin
          bit_cnt_s = '0;
          state_s   = ST_IDLE;
          tx_s      = 1'b1;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        baud_cnt_s = '0;
        bit_cnt_s  = '0;
        tx_s       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes are queued as expectations and a
// line monitor decodes every frame on tx sample by sample against a frame model.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int DIV        = CLK_FREQ / BAUD_RATE;
  localparam int FIFO_DEPTH = 4;
  localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * DIV;
  localparam int N_RAND     = 24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         frames_done = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #(20_000 * 10);
    $display("FAIL watchdog: simulation did not finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  // Line level of bit slot idx in the frame carrying byte b.
  function automatic logic frame_level(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return (($countones(b) % 2) == 1) ^ (PARITY_ODD != 0);
`endif
    return 1'b1;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_byte(input logic [7:0] b, output int acc_cyc);
    int waited = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!tx_ready) begin
      check("push_accept_timeout", tx_ready, 1);
      acc_cyc = -1;
    end else begin
      exp_q.push_back(b);
      acc_cyc = cyc + 1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int fall_cyc);
    int waited = 0;
    while (tx_busy && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    fall_cyc = cyc;
    check(name, tx_busy, 0);
  endtask

  initial begin : monitor
    logic [7:0] b;
    int         bad;
    bit         aborted;
    bit         have;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        start_q.push_back(cyc);
        have = (exp_q.size() > 0);
        b    = have ? exp_q.pop_front() : 8'h00;
        check("frame_was_expected", have, 1);
        bad     = 0;
        aborted = 1'b0;
        for (int i = 0; i < FRAME_CLKS; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (tx !== frame_level(b, i / DIV)) bad++;
        end
        if (!aborted) begin
          frames_done++;
          check($sformatf("frame_bits_%02h_bad_samples", b), bad, 0);
        end
      end
    end
  end

  initial begin : main
    int e;
    int t;
    int s;
    int a[6];
    int frames_expect = 0;

    repeat (3) @(negedge clk);
    check("reset_tx_high", tx, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_tx", tx, 1);
    check("post_reset_ready", tx_ready, 1);
    check("post_reset_busy", tx_busy, 0);

    // Single byte: start bit one edge after accept, busy drops after one frame
    start_q.delete();
    push_byte(8'hA5, e);
    frames_expect++;
    wait_idle("single_idle_timeout", t);
    s = (start_q.size() > 0) ? start_q[0] : -1;
    check("single_start_latency", s, e + 1);
    check("single_busy_fall", t, e + FRAME_CLKS + 1);

    // Burst with tx_valid held high: FIFO fills, then frames run back to back
    start_q.delete();
    for (int i = 0; i < 6; i++) begin
      push_byte(8'(i), a[i]);
      frames_expect++;
      if (i == 4) check("burst_ready_low_when_full", tx_ready, 0);
    end
    check("burst_fifth_accept", a[4], a[0] + 4);
    check("burst_sixth_accept", a[5], a[0] + FRAME_CLKS + 2);
    wait_idle("burst_idle_timeout", t);
    check("burst_busy_fall", t, a[0] + 1 + 6 * FRAME_CLKS);
    check("burst_frame_count", start_q.size(), 6);
    s = 0;
    for (int i = 1; i < start_q.size(); i++) begin
      if (start_q[i] - start_q[i-1] != FRAME_CLKS) s++;
    end
    check("burst_contiguous_gaps", s, 0);

    // Random bytes with random producer gaps, including some full idle periods
    for (int i = 0; i < N_RAND; i++) begin
      push_byte(8'($urandom_range(0, 255)), e);
      frames_expect++;
      if ($urandom_range(0, 5) == 0) begin
        repeat (FRAME_CLKS + $urandom_range(0, 20)) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    wait_idle("random_idle_timeout", t);
    check("random_queue_drained", exp_q.size(), 0);

    // Reset in the middle of data bit 3 of 0xF0 with two more bytes buffered
    push_byte(8'hF0, e);
    push_byte(8'h11, t);
    push_byte(8'h22, t);
    while (cyc < e + 1 + 4 * DIV + DIV / 2) @(negedge clk);
    check("pre_reset_tx_bit3_low", tx, 0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_tx_high", tx, 1);
    check("midreset_busy", tx_busy, 0);
    check("midreset_ready", tx_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("after_reset_busy", tx_busy, 0);
    start_q.delete();
    push_byte(8'h81, e);
    frames_expect++;
    wait_idle("after_reset_idle_timeout", t);
    s = (start_q.size() > 0) ? start_q[0] : -1;
    check("after_reset_start_latency", s, e + 1);
    check("after_reset_single_frame", start_q.size(), 1);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1, frame is 11 bit times
    start_q.delete();
    push_byte(8'h07, e);
    frames_expect++;
    wait_idle("parity_idle_timeout", t);
    check("parity_frame_length", t, e + 11 * DIV + 1);
`endif

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_frames_done", frames_done, frames_expect);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serialises bytes onto the tx line as 8N1 frames, LSB first, at BAUD_RATE derived from CLK_FREQ. A small FIFO decouples the byte producer from line timing, so back-to-back frames go out with no idle gap. Pairs with the existing uart_rx on the same line format: idle-high, one start bit, 8 data bits, one stop bit.

Parameters:
CLK_FREQ, 25_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate; DIVISOR = CLK_FREQ / BAUD_RATE clocks per bit (integer truncation)
FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2
PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
tx_data  input  8  byte to send
tx_valid  input  1  producer has a byte on tx_data
tx_ready  output  1  FIFO can accept; transfer occurs on any rising edge with tx_valid && tx_ready
tx  output  1  serial line, registered, idle high
tx_busy  output  1  high while the FIFO is non-empty or a frame is in progress

Behaviour:
- Reset, asynchronous: tx=1, FIFO emptied, state IDLE, baud counter 0, bit counter 0. tx_ready=1 and tx_busy=0 as soon as reset is released.
- tx_ready = !fifo_full. A push is refused when the FIFO is full, even if a pop happens on the same edge.
- Push and pop on the same edge when the FIFO is neither full nor empty: count is unchanged; data order is preserved.
- Serializer states:
  - IDLE: tx=1. If the FIFO is non-empty: pop the head into the shift register, clear the baud counter, go to START.
  - START: tx=0 for DIVISOR clocks, then go to DATA.
  - DATA: tx=shift[0] for DIVISOR clocks per bit. Shift right after each bit. After bit 7 go to STOP, or to PARITY when the macro is enabled.
  - STOP: tx=1 for DIVISOR clocks. At the end: if the FIFO is non-empty, pop and go straight to START on the same edge (no idle cycle); else go to IDLE.
- Baud counter: width $clog2(DIVISOR). Counts 0..DIVISOR-1, wraps to 0, and the bit boundary is at DIVISOR-1.
- Latency: a byte accepted at edge E into an empty, idle block drives tx low from edge E+1.
- Frame length: exactly 10*DIVISOR clocks, or 11*DIVISOR with parity.
- tx_busy = (state != IDLE) || !fifo_empty. It falls on the edge where STOP completes with the FIFO empty.
- tx changes only at bit boundaries. tx_data is sampled only at accept.
- Reset mid-frame truncates the frame, returns tx high immediately, and discards all buffered bytes.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP and lasts DIVISOR clocks. tx = ^byte XOR PARITY_ODD.
- Undefined: no PARITY state, frames are 8N1, and PARITY_ODD has no effect.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding typedef (IDLE, START, DATA, PARITY, STOP); uart_rx can adopt it later
  - a divisor-calculation function
  - the frame constants DATA_BITS=8 and STOP_BITS=1
- Sub-module uart_tx_fifo: synchronous FIFO with push/pop/full/empty, parameterised by depth and width, same clk/rst_n.
- The serializer and baud counter stay in uart_tx.

Test Plan:
All tests use CLK_FREQ=1_600_000, BAUD_RATE=100_000 (DIVISOR=16) unless stated otherwise.
- Single byte: push 0xA5 at edge E → from E+1, tx = 0,1,0,1,0,0,1,0,1,1, each level held 16 clocks. tx_busy falls at E+161.
- Burst: hold tx_valid high with bytes 0x00..0x05 from edge 1 → tx_ready low after the 5th accept (edge 5). The 6th byte is accepted one edge after frame 0 ends. Six frames go out contiguously, 960 clocks, with no idle high between stop and start.
- Loopback into uart_rx (same parameters): send 0x00, 0xFF, 0x55, 0x3C → rx_valid pulses 4 times with matching rx_data.
- Reset mid-frame: assert rst_n low during data bit 3 of 0xF0 → tx=1 immediately, tx_busy=0, tx_ready=1. A fresh push of 0x81 afterwards is transmitted correctly.
- Parity, with UART_TX_PARITY_EN defined and PARITY_ODD=0: push 0x07 → parity bit 1 and frame of 176 clocks. With PARITY_ODD=1 the parity bit is 0.
